led_fade_beep_seq: RTL and testbench
====================================

Name: led_fade_beep_seq

Overview:
- Upstream sequencer for the RGB-LED/buzzer PWM stage.
- Converts register-level commands from the PS bus into the five 32-bit set-points that the PWM stage consumes: period, R/G/B duty, and buzzer tone period.
- Ramps LED duties linearly toward targets at a fixed tick rate, giving fade and breathing effects.
- Plays N-beep patterns with programmable on/off times.

Parameters:
- TICK_DIV, 50000, clock cycles per tick (1 ms at 50 MHz); must be >= 2.
- PERIOD_RST, 1000, FREQ_Cnt_Set value after reset.

Ports:
- CLK  in  1  system clock
- RST_n  in  1  asynchronous active-low reset
- CFG_Period  in  32  LED PWM period, latched on CFG_Apply
- CFG_R_Target / CFG_G_Target / CFG_B_Target  in  32 each  target duties, latched on CFG_Apply
- CFG_Fade_Step  in  16  duty change per tick; 0 = jump
- CFG_Apply  in  1  one-cycle pulse, latch LED config
- CFG_Beep_Period  in  32  tone period while a beep sounds
- CFG_Beep_On  in  16  beep on time in ticks
- CFG_Beep_Off  in  16  gap time in ticks
- CFG_Beep_Count  in  8  number of beeps
- CFG_Beep_Start  in  1  one-cycle pulse, latch beep config and start
- FREQ_Cnt_Set  out  32  to PWM stage
- LEDR_Puty_Set / LEDG_Puty_Set / LEDB_Puty_Set  out  32 each  to PWM stage
- BZ_Puty_Set  out  32  to PWM stage; 0 = silent
- Fade_Busy  out  1  a fade is in progress
- Beep_Busy  out  1  a beep pattern is in progress

Behaviour:
- Reset (async, RST_n low):
  - FREQ_Cnt_Set = PERIOD_RST; all three duty outputs = 0; BZ_Puty_Set = 0; both busy flags = 0.
  - Tick counter = 0; beep FSM = IDLE; all latched config = 0.
- Tick generator:
  - Free-running counter from 0 to TICK_DIV-1.
  - tick is asserted for one cycle when the counter equals TICK_DIV-1, and the counter wraps to 0.
  - Never restarted by commands.
- Apply (cycle after CFG_Apply is sampled high):
  - FREQ_Cnt_Set <= CFG_Period.
  - Each target <= min(CFG_x_Target, CFG_Period); step <= CFG_Fade_Step.
  - Fade_Busy <= 1 if any current duty differs from its new target.
- Apply while Fade_Busy: targets are re-latched and the fade continues from the current duty values. No jump, no restart.
- Fade, on each tick while Fade_Busy, per channel independently:
  - cur < tgt: cur <= (tgt - cur <= step) ? tgt : cur + step.
  - cur > tgt: cur <= (cur - tgt <= step) ? tgt : cur - step.
  - All comparisons are 32-bit unsigned, so there is no overflow or underflow.
  - step = 0: cur <= tgt on the first tick.
  - Fade_Busy clears in the same cycle the last channel reaches its target.
- Duty outputs are the registered cur values. Latency from a tick to a changed output is 1 cycle.
- Beep FSM states: IDLE, ON, OFF.
  - IDLE + Start with CFG_Beep_Count != 0: latch config; remaining <= Count; enter ON; BZ_Puty_Set <= CFG_Beep_Period; Beep_Busy <= 1.
  - Start with Count = 0: ignored in IDLE. When busy, it aborts to IDLE with BZ_Puty_Set = 0.
  - ON: a phase counter counts ticks.
    - On the max(On,1)-th tick after entry: remaining decrements.
    - If remaining was 1: go to IDLE, BZ = 0, Beep_Busy = 0. The trailing gap is not played.
    - Otherwise: go to OFF, BZ = 0.
  - OFF: on the max(Off,1)-th tick after entry, go to ON and BZ <= latched period.
  - Start while busy: restart immediately in ON with the new config.
  - The first phase may be up to one tick period short, because the tick counter is free-running.
- Simultaneous events:
  - Apply and Start are independent and may coincide.
  - A tick in the same cycle as Apply uses the newly latched targets and step.
  - A tick in the same cycle as Start is not counted toward the new ON phase.
- Reset mid-fade or mid-beep: all state returns to reset values immediately.

Test Plan:
- Reset release with TICK_DIV=4 -> FREQ_Cnt_Set=1000, all duty outputs 0, BZ_Puty_Set 0, both busy flags 0.
- Apply with Period=100, R=50, G=100, B=0, Step=20 -> R goes 20,40,50 on successive ticks; G goes 20,40,60,80,100; Fade_Busy drops on the tick where G reaches 100.
- Apply with R_Target=500, Period=100 -> target clamped to 100; Step=0 gives R=100 on the first tick, then Fade_Busy=0.
- Mid-fade Apply with R_Target=0 while R=40, Step=20 -> R goes 20, 0 with no discontinuity.
- Beep with Period=2000, On=3, Off=2, Count=2 -> BZ_Puty_Set=2000 for 3 ticks, 0 for 2 ticks, 2000 for 3 ticks, then IDLE with Beep_Busy=0 (no trailing gap).
- Start with Count=0 during an ON phase -> next cycle BZ_Puty_Set=0, Beep_Busy=0. Assert RST_n low mid-fade -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/led_fade_beep_seq.sv
// Set-point sequencer for the RGB-LED/buzzer PWM stage: linear duty fades
// toward latched targets on a fixed tick, plus an N-beep tone pattern player.
module led_fade_beep_seq #(
  parameter int unsigned TICK_DIV   = 50000,
  parameter logic [31:0] PERIOD_RST = 32'd1000
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic [31:0] CFG_Period,
  input  logic [31:0] CFG_R_Target,
  input  logic [31:0] CFG_G_Target,
  input  logic [31:0] CFG_B_Target,
  input  logic [15:0] CFG_Fade_Step,
  input  logic        CFG_Apply,
  input  logic [31:0] CFG_Beep_Period,
  input  logic [15:0] CFG_Beep_On,
  input  logic [15:0] CFG_Beep_Off,
  input  logic [7:0]  CFG_Beep_Count,
  input  logic        CFG_Beep_Start,
  output logic [31:0] FREQ_Cnt_Set,
  output logic [31:0] LEDR_Puty_Set,
  output logic [31:0] LEDG_Puty_Set,
  output logic [31:0] LEDB_Puty_Set,
  output logic [31:0] BZ_Puty_Set,
  output logic        Fade_Busy,
  output logic        Beep_Busy,
  output logic [1:0]  Beep_State_Dbg
);

  localparam int unsigned   CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {B_IDLE = 2'd0, B_ON = 2'd1, B_OFF = 2'd2} beep_state_t;

  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  logic [31:0]   freq_q, freq_d;
  logic [31:0]   r_tgt_q, r_tgt_d, g_tgt_q, g_tgt_d, b_tgt_q, b_tgt_d;
  logic [31:0]   r_cur_q, r_cur_d, g_cur_q, g_cur_d, b_cur_q, b_cur_d;
  logic [15:0]   step_q, step_d;
  logic          fade_busy_q, fade_busy_d;

  beep_state_t   beep_state_q, beep_state_d;
  logic [31:0]   beep_per_q, beep_per_d;
  logic [15:0]   beep_on_q, beep_on_d, beep_off_q, beep_off_d;
  logic [7:0]    beep_rem_q, beep_rem_d;
  logic [15:0]   phase_q, phase_d;
  logic [31:0]   bz_q, bz_d;
  logic          beep_busy_q, beep_busy_d;
  logic [15:0]   on_len, off_len, phase_inc;

  // One tick toward the target; step 0 means jump straight there.
  function automatic logic [31:0] fade_step(input logic [31:0] cur,
                                            input logic [31:0] tgt,
                                            input logic [15:0] step);
    logic [31:0] s;
    s = {16'd0, step};
    if (cur < tgt)
      fade_step = (step == 16'd0 || (tgt - cur) <= s) ? tgt : cur + s;
    else if (cur > tgt)
      fade_step = (step == 16'd0 || (cur - tgt) <= s) ? tgt : cur - s;
    else
      fade_step = cur;
  endfunction

  function automatic logic [31:0] clamp(input logic [31:0] v, input logic [31:0] lim);
    clamp = (v > lim) ? lim : v;
  endfunction

  assign tick = (tick_cnt_q == TICK_LAST);

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + CW'(1);
    freq_d  = freq_q;
    r_tgt_d = r_tgt_q;
    g_tgt_d = g_tgt_q;
    b_tgt_d = b_tgt_q;
    step_d  = step_q;
    if (CFG_Apply) begin
      freq_d  = CFG_Period;
      r_tgt_d = clamp(CFG_R_Target, CFG_Period);
      g_tgt_d = clamp(CFG_G_Target, CFG_Period);
      b_tgt_d = clamp(CFG_B_Target, CFG_Period);
      step_d  = CFG_Fade_Step;
    end
    // Stepping uses the freshly latched targets, so an Apply on a tick edge takes effect at once.
    r_cur_d = r_cur_q;
    g_cur_d = g_cur_q;
    b_cur_d = b_cur_q;
    if (tick) begin
      r_cur_d = fade_step(r_cur_q, r_tgt_d, step_d);
      g_cur_d = fade_step(g_cur_q, g_tgt_d, step_d);
      b_cur_d = fade_step(b_cur_q, b_tgt_d, step_d);
    end
    fade_busy_d = (r_cur_d != r_tgt_d) || (g_cur_d != g_tgt_d) || (b_cur_d != b_tgt_d);
  end

  assign on_len    = (beep_on_q  == 16'd0) ? 16'd1 : beep_on_q;
  assign off_len   = (beep_off_q == 16'd0) ? 16'd1 : beep_off_q;
  assign phase_inc = phase_q + 16'd1;

  always_comb begin
    beep_state_d = beep_state_q;
    beep_per_d   = beep_per_q;
    beep_on_d    = beep_on_q;
    beep_off_d   = beep_off_q;
    beep_rem_d   = beep_rem_q;
    phase_d      = phase_q;
    bz_d         = bz_q;
    beep_busy_d  = beep_busy_q;
    if (CFG_Beep_Start) begin
      if (CFG_Beep_Count != 8'd0) begin
        beep_per_d   = CFG_Beep_Period;
        beep_on_d    = CFG_Beep_On;
        beep_off_d   = CFG_Beep_Off;
        beep_rem_d   = CFG_Beep_Count;
        phase_d      = '0;
        beep_state_d = B_ON;
        bz_d         = CFG_Beep_Period;
        beep_busy_d  = 1'b1;
      end else if (beep_state_q != B_IDLE) begin
        beep_state_d = B_IDLE;
        beep_rem_d   = '0;
        phase_d      = '0;
        bz_d         = '0;
        beep_busy_d  = 1'b0;
      end
    end else if (tick) begin
      case (beep_state_q)
        B_ON: begin
          if (phase_inc >= on_len) begin
            beep_rem_d = beep_rem_q - 8'd1;
            phase_d    = '0;
            bz_d       = '0;
            if (beep_rem_q == 8'd1) begin
              beep_state_d = B_IDLE;
              beep_busy_d  = 1'b0;
            end else begin
              beep_state_d = B_OFF;
            end
          end else begin
            phase_d = phase_inc;
          end
        end
        B_OFF: begin
          if (phase_inc >= off_len) begin
            phase_d      = '0;
            beep_state_d = B_ON;
            bz_d         = beep_per_q;
          end else begin
            phase_d = phase_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      tick_cnt_q   <= '0;
      freq_q       <= PERIOD_RST;
      r_tgt_q      <= '0;
      g_tgt_q      <= '0;
      b_tgt_q      <= '0;
      r_cur_q      <= '0;
      g_cur_q      <= '0;
      b_cur_q      <= '0;
      step_q       <= '0;
      fade_busy_q  <= 1'b0;
      beep_state_q <= B_IDLE;
      beep_per_q   <= '0;
      beep_on_q    <= '0;
      beep_off_q   <= '0;
      beep_rem_q   <= '0;
      phase_q      <= '0;
      bz_q         <= '0;
      beep_busy_q  <= 1'b0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      freq_q       <= freq_d;
      r_tgt_q      <= r_tgt_d;
      g_tgt_q      <= g_tgt_d;
      b_tgt_q      <= b_tgt_d;
      r_cur_q      <= r_cur_d;
      g_cur_q      <= g_cur_d;
      b_cur_q      <= b_cur_d;
      step_q       <= step_d;
      fade_busy_q  <= fade_busy_d;
      beep_state_q <= beep_state_d;
      beep_per_q   <= beep_per_d;
      beep_on_q    <= beep_on_d;
      beep_off_q   <= beep_off_d;
      beep_rem_q   <= beep_rem_d;
      phase_q      <= phase_d;
      bz_q         <= bz_d;
      beep_busy_q  <= beep_busy_d;
    end
  end

  assign FREQ_Cnt_Set   = freq_q;
  assign LEDR_Puty_Set  = r_cur_q;
  assign LEDG_Puty_Set  = g_cur_q;
  assign LEDB_Puty_Set  = b_cur_q;
  assign BZ_Puty_Set    = bz_q;
  assign Fade_Busy      = fade_busy_q;
  assign Beep_Busy      = beep_busy_q;
  assign Beep_State_Dbg = beep_state_q;

endmodule

// File: tb/tb_led_fade_beep_seq.sv
// Directed bench for led_fade_beep_seq with TICK_DIV=4; ticks land on every
// 4th rising edge after reset release, tracked by a local edge counter.
module tb_led_fade_beep_seq;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic [31:0] CFG_Period, CFG_R_Target, CFG_G_Target, CFG_B_Target;
  logic [15:0] CFG_Fade_Step;
  logic        CFG_Apply;
  logic [31:0] CFG_Beep_Period;
  logic [15:0] CFG_Beep_On, CFG_Beep_Off;
  logic [7:0]  CFG_Beep_Count;
  logic        CFG_Beep_Start;
  logic [31:0] FREQ_Cnt_Set, LEDR_Puty_Set, LEDG_Puty_Set, LEDB_Puty_Set, BZ_Puty_Set;
  logic        Fade_Busy, Beep_Busy;
  logic [1:0]  Beep_State_Dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  led_fade_beep_seq #(.TICK_DIV(4), .PERIOD_RST(32'd1000)) dut (
    .CLK(CLK), .RST_n(RST_n),
    .CFG_Period(CFG_Period), .CFG_R_Target(CFG_R_Target),
    .CFG_G_Target(CFG_G_Target), .CFG_B_Target(CFG_B_Target),
    .CFG_Fade_Step(CFG_Fade_Step), .CFG_Apply(CFG_Apply),
    .CFG_Beep_Period(CFG_Beep_Period), .CFG_Beep_On(CFG_Beep_On),
    .CFG_Beep_Off(CFG_Beep_Off), .CFG_Beep_Count(CFG_Beep_Count),
    .CFG_Beep_Start(CFG_Beep_Start),
    .FREQ_Cnt_Set(FREQ_Cnt_Set), .LEDR_Puty_Set(LEDR_Puty_Set),
    .LEDG_Puty_Set(LEDG_Puty_Set), .LEDB_Puty_Set(LEDB_Puty_Set),
    .BZ_Puty_Set(BZ_Puty_Set), .Fade_Busy(Fade_Busy), .Beep_Busy(Beep_Busy),
    .Beep_State_Dbg(Beep_State_Dbg)
  );

  // Clock / reset-relative edge counter
  always #5 CLK = ~CLK;

  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance to the falling edge right after the next tick edge.
  task automatic tick_step();
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while ((cyc % 4) != 0 && n < 12);
    if ((cyc % 4) != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL tick_timeout got=%0d exp=0", cyc % 4);
    end
  endtask

  task automatic apply(input logic [31:0] per, input logic [31:0] r, input logic [31:0] g,
                       input logic [31:0] b, input logic [15:0] step);
    CFG_Period = per; CFG_R_Target = r; CFG_G_Target = g; CFG_B_Target = b;
    CFG_Fade_Step = step; CFG_Apply = 1'b1;
    @(negedge CLK);
    CFG_Apply = 1'b0;
  endtask

  task automatic beep_start(input logic [31:0] per, input logic [15:0] on_t,
                            input logic [15:0] off_t, input logic [7:0] cnt);
    CFG_Beep_Period = per; CFG_Beep_On = on_t; CFG_Beep_Off = off_t;
    CFG_Beep_Count = cnt; CFG_Beep_Start = 1'b1;
    @(negedge CLK);
    CFG_Beep_Start = 1'b0;
  endtask

  initial begin
    RST_n = 1'b0;
    CFG_Period = '0; CFG_R_Target = '0; CFG_G_Target = '0; CFG_B_Target = '0;
    CFG_Fade_Step = '0; CFG_Apply = 1'b0;
    CFG_Beep_Period = '0; CFG_Beep_On = '0; CFG_Beep_Off = '0;
    CFG_Beep_Count = '0; CFG_Beep_Start = 1'b0;
    repeat (3) @(negedge CLK);
    check_eq("rst_freq", FREQ_Cnt_Set, 32'd1000);
    check_eq("rst_r", LEDR_Puty_Set, 32'd0);
    check_eq("rst_g", LEDG_Puty_Set, 32'd0);
    check_eq("rst_b", LEDB_Puty_Set, 32'd0);
    check_eq("rst_bz", BZ_Puty_Set, 32'd0);
    check_eq("rst_fbusy", {31'd0, Fade_Busy}, 32'd0);
    check_eq("rst_bbusy", {31'd0, Beep_Busy}, 32'd0);
    RST_n = 1'b1;

    // Linear fade, G limits the end of the fade
    apply(32'd100, 32'd50, 32'd100, 32'd0, 16'd20);
    check_eq("ap_freq", FREQ_Cnt_Set, 32'd100);
    check_eq("ap_busy", {31'd0, Fade_Busy}, 32'd1);
    check_eq("ap_r0", LEDR_Puty_Set, 32'd0);
    tick_step(); check_eq("f1_r", LEDR_Puty_Set, 32'd20); check_eq("f1_g", LEDG_Puty_Set, 32'd20);
    tick_step(); check_eq("f2_r", LEDR_Puty_Set, 32'd40); check_eq("f2_g", LEDG_Puty_Set, 32'd40);
    tick_step(); check_eq("f3_r", LEDR_Puty_Set, 32'd50); check_eq("f3_g", LEDG_Puty_Set, 32'd60);
    tick_step(); check_eq("f4_g", LEDG_Puty_Set, 32'd80);
    check_eq("f4_busy", {31'd0, Fade_Busy}, 32'd1);
    tick_step(); check_eq("f5_g", LEDG_Puty_Set, 32'd100);
    check_eq("f5_busy", {31'd0, Fade_Busy}, 32'd0);
    check_eq("f5_b", LEDB_Puty_Set, 32'd0);

    // Target clamped to period, step 0 jumps
    apply(32'd100, 32'd500, 32'd100, 32'd0, 16'd0);
    check_eq("clamp_busy", {31'd0, Fade_Busy}, 32'd1);
    check_eq("clamp_r_pre", LEDR_Puty_Set, 32'd50);
    tick_step(); check_eq("clamp_r", LEDR_Puty_Set, 32'd100);
    check_eq("clamp_idle", {31'd0, Fade_Busy}, 32'd0);

    // Mid-fade retarget continues from the current duty
    apply(32'd100, 32'd0, 32'd100, 32'd0, 16'd0);
    tick_step(); check_eq("jump0_r", LEDR_Puty_Set, 32'd0);
    apply(32'd100, 32'd80, 32'd100, 32'd0, 16'd20);
    tick_step(); check_eq("up1_r", LEDR_Puty_Set, 32'd20);
    tick_step(); check_eq("up2_r", LEDR_Puty_Set, 32'd40);
    apply(32'd100, 32'd0, 32'd100, 32'd0, 16'd20);
    check_eq("re_r", LEDR_Puty_Set, 32'd40);
    check_eq("re_busy", {31'd0, Fade_Busy}, 32'd1);
    tick_step(); check_eq("dn1_r", LEDR_Puty_Set, 32'd20);
    tick_step(); check_eq("dn2_r", LEDR_Puty_Set, 32'd0);
    check_eq("dn2_busy", {31'd0, Fade_Busy}, 32'd0);

    // Two-beep pattern, no trailing gap
    beep_start(32'd2000, 16'd3, 16'd2, 8'd2);
    check_eq("bp_start", BZ_Puty_Set, 32'd2000);
    check_eq("bp_busy", {31'd0, Beep_Busy}, 32'd1);
    tick_step(); check_eq("on1_t1", BZ_Puty_Set, 32'd2000);
    tick_step(); check_eq("on1_t2", BZ_Puty_Set, 32'd2000);
    tick_step(); check_eq("on1_t3", BZ_Puty_Set, 32'd0);
    check_eq("gap_busy", {31'd0, Beep_Busy}, 32'd1);
    tick_step(); check_eq("off_t1", BZ_Puty_Set, 32'd0);
    tick_step(); check_eq("off_t2", BZ_Puty_Set, 32'd2000);
    tick_step(); check_eq("on2_t1", BZ_Puty_Set, 32'd2000);
    tick_step(); check_eq("on2_t2", BZ_Puty_Set, 32'd2000);
    tick_step(); check_eq("on2_t3", BZ_Puty_Set, 32'd0);
    check_eq("bp_done", {31'd0, Beep_Busy}, 32'd0);

    // Count=0 aborts when busy, ignored when idle
    beep_start(32'd2000, 16'd3, 16'd2, 8'd2);
    tick_step(); check_eq("ab_on", BZ_Puty_Set, 32'd2000);
    beep_start(32'd2000, 16'd3, 16'd2, 8'd0);
    check_eq("ab_bz", BZ_Puty_Set, 32'd0);
    check_eq("ab_busy", {31'd0, Beep_Busy}, 32'd0);
    beep_start(32'd900, 16'd3, 16'd2, 8'd0);
    check_eq("ign_bz", BZ_Puty_Set, 32'd0);
    check_eq("ign_busy", {31'd0, Beep_Busy}, 32'd0);

    // On/Off of 0 behave as 1; Start while busy restarts with new config
    beep_start(32'd700, 16'd1, 16'd0, 8'd3);
    check_eq("z_on", BZ_Puty_Set, 32'd700);
    tick_step(); check_eq("z_off", BZ_Puty_Set, 32'd0);
    tick_step(); check_eq("z_on2", BZ_Puty_Set, 32'd700);
    beep_start(32'd500, 16'd0, 16'd0, 8'd1);
    check_eq("rs_bz", BZ_Puty_Set, 32'd500);
    tick_step(); check_eq("rs_end", BZ_Puty_Set, 32'd0);
    check_eq("rs_busy", {31'd0, Beep_Busy}, 32'd0);

    // Asynchronous reset mid-fade and mid-beep
    apply(32'd100, 32'd100, 32'd100, 32'd0, 16'd10);
    tick_step(); tick_step();
    check_eq("pre_rst_r", LEDR_Puty_Set, 32'd20);
    beep_start(32'd2000, 16'd3, 16'd2, 8'd2);
    check_eq("pre_rst_bz", BZ_Puty_Set, 32'd2000);
    #2 RST_n = 1'b0;
    #1;
    check_eq("ar_freq", FREQ_Cnt_Set, 32'd1000);
    check_eq("ar_r", LEDR_Puty_Set, 32'd0);
    check_eq("ar_g", LEDG_Puty_Set, 32'd0);
    check_eq("ar_bz", BZ_Puty_Set, 32'd0);
    check_eq("ar_fbusy", {31'd0, Fade_Busy}, 32'd0);
    check_eq("ar_bbusy", {31'd0, Beep_Busy}, 32'd0);
    @(negedge CLK);
    RST_n = 1'b1;
    repeat (2) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
